// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline memory stage.
//   mem_size_t  : access width of a load/store (byte, half, word)
//   mem_state_t : memory-stage access sequencer states
//   is_misaligned() : natural-alignment check for a given size and address
package mips_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    // Halfwords need an even address, words a multiple of four.
    // The unused size encoding is treated like a word.
    function automatic logic is_misaligned(mem_size_t size, logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_BYTE: bad = 1'b0;
            MEM_HALF: bad = addr_lo[0];
            default:  bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
//   dmemReq    : request valid, held until dmemAck
//   dmemWe     : write enable
//   dmemAddr   : word-aligned address
//   dmemWdata  : lane-replicated store data
//   dmemByteEn : byte enables, bit i = byte lane i (little-endian)
//   dmemRdata  : read word, valid with dmemAck
//   dmemAck    : access complete, sampled on the rising clock edge
interface mem_stage_if;

    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [3:0]  dmemByteEn;
    logic [31:0] dmemRdata;
    logic        dmemAck;

    modport master (
        output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemByteEn,
        input  dmemRdata, dmemAck
    );

    modport slave (
        input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemByteEn,
        output dmemRdata, dmemAck
    );

endinterface

// File: rtl/mem_align.sv
// Combinational lane steering for the memory stage.
//   mem_size   : access width
//   mem_signed : sign-extend sub-word loads (else zero-extend)
//   addr_lo    : low two address bits selecting the byte/half lane
//   store_data : rt value for stores
//   rdata      : word returned by data memory
//   wdata      : store data replicated across lanes
//   byte_en    : byte enables for the store/load lanes
//   load_data  : extracted and extended load result
module mem_align
    import mips_pkg::*;
(
    input  mem_size_t   mem_size,
    input  logic        mem_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        wdata     = store_data;
        byte_en   = 4'b1111;
        load_data = rdata;

        case (mem_size)
            MEM_BYTE: begin
                wdata     = {4{store_data[7:0]}};
                byte_en   = 4'b0001 << addr_lo;
                load_data = {{24{mem_signed & byte_sel[7]}}, byte_sel};
            end
            MEM_HALF: begin
                wdata     = {2{store_data[15:0]}};
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = {{16{mem_signed & half_sel[15]}}, half_sel};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline.
// Issues loads/stores on a req/ack data-memory bus, aligns/extends load data,
// stalls upstream while an access is outstanding and flags misaligned or
// timed-out accesses.
//   clock, reset_n        : stage clock, asynchronous active-low reset
//   MemRead, MemWrite     : load / store request from EX/MEM
//   MemToReg, RegWrite    : writeback controls from EX/MEM
//   memSize, memSigned    : access width and load extension
//   aluResult, storeData  : effective address and store data
//   regWriteDst, id       : destination register and instruction tag
//   dmem                  : data-memory bus (master side)
//   stall                 : freeze PC, IF/ID, ID/EX, EX/MEM
//   misalign, busError    : fault flags for the current instruction
//   *_mem                 : values forwarded to MEM/WB
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  mem_size_t   memSize,
    input  logic        memSigned,
    input  logic [31:0] aluResult,
    input  logic [31:0] storeData,
    input  logic [4:0]  regWriteDst,
    input  logic [31:0] id,
    mem_stage_if.master dmem,
    output logic        stall,
    output logic        misalign,
    output logic        busError,
    output logic        MemToReg_mem,
    output logic        RegWrite_mem,
    output logic [31:0] memReadData_mem,
    output logic [31:0] memAddr_mem,
    output logic [4:0]  regWriteDst_mem,
    output logic [31:0] id_mem
);

    localparam int unsigned    CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);

    mem_state_t    state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   cap_data;
    logic          err_q;

    // Request captured at issue so the bus stays stable throughout WAIT.
    logic [31:0]   h_addr;
    logic [31:0]   h_store;
    mem_size_t     h_size;
    logic          h_signed;
    logic          h_we;

    logic          mem_op;
    logic          mis_c;
    logic          issue;
    logic          in_wait;
    logic          req;
    logic          fault;

    logic [31:0]   cur_addr;
    logic [31:0]   cur_store;
    mem_size_t     cur_size;
    logic          cur_signed;
    logic          cur_we;

    logic [31:0]   al_wdata;
    logic [3:0]    al_byte_en;
    logic [31:0]   al_load;
    logic [31:0]   load_val;

    always_comb begin
        mem_op     = MemRead | MemWrite;
        mis_c      = mem_op & is_misaligned(memSize, aluResult[1:0]);
        issue      = (state == IDLE) & mem_op & ~mis_c;
        in_wait    = (state == WAIT);
        req        = issue | in_wait;

        cur_addr   = in_wait ? h_addr   : aluResult;
        cur_store  = in_wait ? h_store  : storeData;
        cur_size   = in_wait ? h_size   : memSize;
        cur_signed = in_wait ? h_signed : memSigned;
        cur_we     = in_wait ? h_we     : MemWrite;
    end

    mem_align u_align (
        .mem_size   (cur_size),
        .mem_signed (cur_signed),
        .addr_lo    (cur_addr[1:0]),
        .store_data (cur_store),
        .rdata      (dmem.dmemRdata),
        .wdata      (al_wdata),
        .byte_en    (al_byte_en),
        .load_data  (al_load)
    );

    // Stores complete with no read data.
    assign load_val = cur_we ? '0 : al_load;

    // Control outputs are gated by reset_n so they drop the moment reset is
    // asserted, even though the state register is already forced to IDLE.
    always_comb begin
        dmem.dmemReq    = reset_n & req;
        dmem.dmemWe     = reset_n & req & cur_we;
        dmem.dmemAddr   = {cur_addr[31:2], 2'b00};
        dmem.dmemWdata  = al_wdata;
        dmem.dmemByteEn = al_byte_en;

        stall           = reset_n & req;
        misalign        = reset_n & (state == IDLE) & mis_c;
        busError        = (state == DONE) & err_q;
        fault           = misalign | busError;

        RegWrite_mem    = reset_n & RegWrite & ~fault;
        MemToReg_mem    = reset_n & MemToReg & ~fault;
        memReadData_mem = (state == DONE) ? cap_data : '0;
        memAddr_mem     = aluResult;
        regWriteDst_mem = regWriteDst;
        id_mem          = id;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            cap_data <= '0;
            err_q    <= 1'b0;
            h_addr   <= '0;
            h_store  <= '0;
            h_size   <= MEM_BYTE;
            h_signed <= 1'b0;
            h_we     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        h_addr   <= aluResult;
                        h_store  <= storeData;
                        h_size   <= memSize;
                        h_signed <= memSigned;
                        h_we     <= MemWrite;
                        err_q    <= 1'b0;
                        if (dmem.dmemAck) begin
                            cap_data <= load_val;
                            state    <= DONE;
                        end else begin
                            // Counter holds the number of WAIT cycles seen,
                            // including the current one.
                            wait_cnt <= CW'(1);
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem.dmemAck) begin
                        cap_data <= load_val;
                        wait_cnt <= '0;
                        state    <= DONE;
                    end else if (wait_cnt == CNT_MAX) begin
                        cap_data <= '0;
                        err_q    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
